fwd_hazard_stage: RTL and testbench

Registered decode-side hazard stage for the 16-bit pipeline. It sits between fetch and the decoder/ALU operand muxes. For each instruction it computes forwarding selects for the A operand (bits [13:11]) and the B operand (bits [10:8]) against a parametrised window of previously issued instructions. It also detects load-use hazards and resolves them by stalling fetch for one cycle and inserting a bubble, which the earlier fixed two-deep combinational detector could not do.

---
 rtl/fwd_hazard_stage.sv | 93 +++++++++
 tb/tb_fwd_hazard_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_stage.sv
// Decode-side hazard stage: registers each instruction with operand forward distances
// against a DEPTH-deep issue history, and inserts one bubble per load-use hazard.
module fwd_hazard_stage #(
    parameter int DEPTH = 2,
    localparam int SW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          stall,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [15:0]   out_instr,
    output logic [SW-1:0] out_fwd_a,
    output logic [SW-1:0] out_fwd_b
);

    logic [DEPTH:1] hist_valid;
    logic [15:0]    hist_instr [1:DEPTH];
    logic [SW-1:0]  fwd_a;
    logic [SW-1:0]  fwd_b;
    logic           load_use;
    logic           accept;

    function automatic logic is_prod(input logic [15:0] i);
        return (i[15:14] == 2'b11 && i[7:4] <= 4'd12 && i[7:4] != 4'd5 && i[7:4] != 4'd7)
            || i[15:11] == 5'b10001 || i[15:11] == 5'b10000;
    endfunction

    function automatic logic is_load(input logic [15:0] i);
        return i[15:14] == 2'b00;
    endfunction

    function automatic logic reads_a(input logic [15:0] i);
        return (i[15:14] == 2'b11 && (i[7:4] <= 4'd6 || i[7:4] == 4'd13)) || i[15:14] == 2'b01;
    endfunction

    function automatic logic reads_b(input logic [15:0] i);
        return (i[15:14] == 2'b11 && (i[7:4] <= 4'd5 || (i[7:4] >= 4'd8 && i[7:4] <= 4'd11)))
            || i[15:14] == 2'b00 || i[15:14] == 2'b01
            || (i[15:14] == 2'b10 && (i[13:11] == 3'd1 || i[13:11] == 3'd2 || i[13:11] == 3'd6));
    endfunction

    // Walk oldest to youngest so the youngest matching producer overwrites older hits;
    // loads write [13:11] and only become forwardable once they are two slots back.
    always_comb begin
        logic [2:0] dest;
        logic       hit;
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            dest = is_load(hist_instr[k]) ? hist_instr[k][13:11] : hist_instr[k][10:8];
            hit  = hist_valid[k] && (is_prod(hist_instr[k]) || (is_load(hist_instr[k]) && k >= 2));
            if (hit && dest == in_instr[13:11]) fwd_a = SW'(k);
            if (hit && dest == in_instr[10:8])  fwd_b = SW'(k);
        end
        if (!reads_a(in_instr)) fwd_a = '0;
        if (!reads_b(in_instr)) fwd_b = '0;
    end

    always_comb begin
        load_use = hist_valid[1] && is_load(hist_instr[1]) && in_valid
                && ((reads_a(in_instr) && in_instr[13:11] == hist_instr[1][13:11])
                 || (reads_b(in_instr) && in_instr[10:8]  == hist_instr[1][13:11]));
        in_ready = rst_n && !stall && !flush && !load_use;
        accept   = in_ready && in_valid;
    end

    // Flush beats stall; a refused or absent instruction enters as a zeroed bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            hist_valid <= '0;
            for (int k = 1; k <= DEPTH; k++) hist_instr[k] <= '0;
            out_fwd_a  <= '0;
            out_fwd_b  <= '0;
        end else if (!stall) begin
            for (int k = 2; k <= DEPTH; k++) begin
                hist_valid[k] <= hist_valid[k-1];
                hist_instr[k] <= hist_instr[k-1];
            end
            hist_valid[1] <= accept;
            hist_instr[1] <= accept ? in_instr : 16'h0000;
            out_fwd_a     <= accept ? fwd_a : '0;
            out_fwd_b     <= accept ? fwd_b : '0;
        end
    end

    assign out_valid = hist_valid[1];
    assign out_instr = hist_instr[1];

endmodule

// File: tb/tb_fwd_hazard_stage.sv
// Directed bench for fwd_hazard_stage; three depths share one stimulus stream
// since acceptance and P[1] behaviour do not depend on DEPTH.
module tb_fwd_hazard_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic        in_valid;
    logic [15:0] in_instr;

    logic        rdy2, ov2, rdy4, ov4, rdy1, ov1;
    logic [15:0] oi2, oi4, oi1;
    logic [1:0]  fa2, fb2;
    logic [2:0]  fa4, fb4;
    logic [0:0]  fa1, fb1;

    int total = 0;
    int bad = 0;

    localparam logic [15:0] NOP = 16'hB800;
    localparam logic [15:0] LD5 = 16'h2800;
    localparam logic [15:0] LI4 = 16'h8400;
    localparam logic [15:0] ADDI4 = 16'h8C00;

    fwd_hazard_stage #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(rdy2),
        .out_valid(ov2), .out_instr(oi2), .out_fwd_a(fa2), .out_fwd_b(fb2)
    );

    fwd_hazard_stage #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(rdy4),
        .out_valid(ov4), .out_instr(oi4), .out_fwd_a(fa4), .out_fwd_b(fb4)
    );

    fwd_hazard_stage #(.DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(rdy1),
        .out_valid(ov1), .out_instr(oi1), .out_fwd_a(fa1), .out_fwd_b(fb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu(input logic [2:0] a, input logic [2:0] b, input logic [3:0] op);
        return {2'b11, a, b, op, 4'b0000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        flush = 1'b1;
        stall = 1'b0;
        in_valid = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic issue(input logic [15:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b1; in_instr = alu(3'd1, 3'd2, 4'd0);
        repeat (3) tick();
        total++; if (ov2 !== 1'b0) begin $display("FAIL reset_valid got=%0h want=0", ov2); bad++; end
        total++; if (oi2 !== 16'h0) begin $display("FAIL reset_instr got=%0h want=0", oi2); bad++; end
        total++; if (rdy2 !== 1'b0) begin $display("FAIL reset_ready got=%0h want=0", rdy2); bad++; end
        total++; if (fa2 !== 2'd0 || fb2 !== 2'd0) begin $display("FAIL reset_fwd got=%0h/%0h want=0/0", fa2, fb2); bad++; end
        total++; if ({rdy4, ov4, rdy1, ov1} !== 4'b0) begin $display("FAIL reset_other_ready_valid got=%0h want=0", {rdy4, ov4, rdy1, ov1}); bad++; end
        total++; if ({oi4, oi1, fa4, fb4, fa1, fb1} !== '0) begin $display("FAIL reset_other_out got=%0h want=0", {oi4, oi1, fa4, fb4, fa1, fb1}); bad++; end
        rst_n = 1'b1;
        #1;
        total++; if (rdy2 !== 1'b1) begin $display("FAIL release_ready got=%0h want=1", rdy2); bad++; end
        tick();
        total++; if (ov2 !== 1'b1 || oi2 !== alu(3'd1, 3'd2, 4'd0)) begin $display("FAIL first_out got=%0h/%0h want=1/%0h", ov2, oi2, alu(3'd1, 3'd2, 4'd0)); bad++; end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        clear_hist();
        issue(alu(3'd1, 3'd3, 4'd0));
        issue(alu(3'd3, 3'd3, 4'd0));
        total++; if (fa2 !== 2'd1 || fb2 !== 2'd1) begin $display("FAIL b2b_d2 got=%0d/%0d want=1/1", fa2, fb2); bad++; end
        total++; if (fa4 !== 3'd1 || fa1 !== 1'd1) begin $display("FAIL b2b_d4_d1 got=%0d/%0d want=1/1", fa4, fa1); bad++; end
        clear_hist();
        issue(alu(3'd1, 3'd3, 4'd0));
        issue(NOP);
        issue(alu(3'd3, 3'd3, 4'd0));
        total++; if (fa2 !== 2'd2 || fb2 !== 2'd2) begin $display("FAIL gap_d2 got=%0d/%0d want=2/2", fa2, fb2); bad++; end
        total++; if (fa4 !== 3'd2) begin $display("FAIL gap_d4 got=%0d want=2", fa4); bad++; end
        total++; if (fa1 !== 1'd0 || fb1 !== 1'd0) begin $display("FAIL gap_d1 got=%0d/%0d want=0/0", fa1, fb1); bad++; end
        in_valid = 1'b0;
    endtask

    task automatic test_youngest_wins();
        clear_hist();
        issue(alu(3'd0, 3'd2, 4'd0));
        issue(NOP);
        issue(alu(3'd0, 3'd2, 4'd0));
        issue(alu(3'd2, 3'd5, 4'd0));
        total++; if (fa4 !== 3'd1 || fb4 !== 3'd0) begin $display("FAIL young_d4 got=%0d/%0d want=1/0", fa4, fb4); bad++; end
        clear_hist();
        issue(alu(3'd0, 3'd2, 4'd0));
        issue(NOP);
        issue(NOP);
        issue(alu(3'd2, 3'd5, 4'd0));
        total++; if (fa4 !== 3'd3) begin $display("FAIL dist3_d4 got=%0d want=3", fa4); bad++; end
        total++; if (fa2 !== 2'd0) begin $display("FAIL dist3_d2 got=%0d want=0", fa2); bad++; end
        in_valid = 1'b0;
    endtask

    task automatic test_load_use();
        clear_hist();
        issue(LD5);
        in_valid = 1'b1; in_instr = alu(3'd5, 3'd1, 4'd0); stall = 1'b1;
        #1;
        total++; if (rdy2 !== 1'b0) begin $display("FAIL lu_stall_ready got=%0h want=0", rdy2); bad++; end
        tick();
        total++; if (ov2 !== 1'b1 || oi2 !== LD5) begin $display("FAIL lu_stall_hold got=%0h/%0h want=1/%0h", ov2, oi2, LD5); bad++; end
        stall = 1'b0;
        #1;
        total++; if (rdy2 !== 1'b0) begin $display("FAIL lu_ready got=%0h want=0", rdy2); bad++; end
        tick();
        total++; if (ov2 !== 1'b0 || oi2 !== 16'h0) begin $display("FAIL lu_bubble got=%0h/%0h want=0/0", ov2, oi2); bad++; end
        total++; if (rdy2 !== 1'b1) begin $display("FAIL lu_ready_after got=%0h want=1", rdy2); bad++; end
        tick();
        total++; if (ov2 !== 1'b1 || oi2 !== alu(3'd5, 3'd1, 4'd0)) begin $display("FAIL lu_out got=%0h/%0h want=1/%0h", ov2, oi2, alu(3'd5, 3'd1, 4'd0)); bad++; end
        total++; if (fa2 !== 2'd2 || fb2 !== 2'd0 || fa4 !== 3'd2) begin $display("FAIL lu_fwd got=%0d/%0d/%0d want=2/0/2", fa2, fb2, fa4); bad++; end
        total++; if (fa1 !== 1'd0) begin $display("FAIL lu_d1_fwd got=%0d want=0", fa1); bad++; end
        in_valid = 1'b0;
    endtask

    task automatic test_flush_stall();
        clear_hist();
        issue(alu(3'd1, 3'd4, 4'd0));
        in_instr = alu(3'd4, 3'd4, 4'd0); flush = 1'b1; stall = 1'b1;
        #1;
        total++; if (rdy2 !== 1'b0) begin $display("FAIL flush_ready got=%0h want=0", rdy2); bad++; end
        tick();
        total++; if (ov2 !== 1'b0 || oi2 !== 16'h0 || fa2 !== 2'd0) begin $display("FAIL flush_out got=%0h/%0h/%0d want=0/0/0", ov2, oi2, fa2); bad++; end
        flush = 1'b0; stall = 1'b0;
        tick();
        total++; if (ov2 !== 1'b1 || fa2 !== 2'd0 || fb2 !== 2'd0 || fa4 !== 3'd0) begin $display("FAIL flush_after got=%0h/%0d/%0d/%0d want=1/0/0/0", ov2, fa2, fb2, fa4); bad++; end
        in_valid = 1'b0;
    endtask

    task automatic test_non_producers();
        clear_hist();
        issue(alu(3'd1, 3'd4, 4'd5));
        issue(alu(3'd4, 3'd4, 4'd0));
        total++; if (fa2 !== 2'd0 || fb2 !== 2'd0) begin $display("FAIL cmp_fwd got=%0d/%0d want=0/0", fa2, fb2); bad++; end
        clear_hist();
        issue(alu(3'd1, 3'd4, 4'd7));
        issue(alu(3'd4, 3'd4, 4'd0));
        total++; if (fa2 !== 2'd0 || fb2 !== 2'd0) begin $display("FAIL op7_fwd got=%0d/%0d want=0/0", fa2, fb2); bad++; end
        clear_hist();
        issue(LI4);
        issue(alu(3'd4, 3'd4, 4'd0));
        total++; if (fa2 !== 2'd1 || fb2 !== 2'd1) begin $display("FAIL li_fwd got=%0d/%0d want=1/1", fa2, fb2); bad++; end
        clear_hist();
        issue(ADDI4);
        issue(alu(3'd4, 3'd4, 4'd0));
        total++; if (fa2 !== 2'd1) begin $display("FAIL addi_fwd got=%0d want=1", fa2); bad++; end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_youngest_wins();
        test_load_use();
        test_flush_stall();
        test_non_producers();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
